// File: rtl/i2s_transmitter.sv
// Philips I2S output stage: converts an offset-binary mono sample to two's complement
// and sends it on both channels, with BCLK/LRCLK derived from the system clock.
module i2s_transmitter #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int SLOT_WIDTH      = 32,
    parameter int BCLK_DIV        = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [AUDIO_BIT_WIDTH-1:0] audio_in,
    output logic                       sample_req,
    output logic                       i2s_bclk,
    output logic                       i2s_lrclk,
    output logic                       i2s_sdata
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_POS = BIT_W'(SLOT_WIDTH);

    if (SLOT_WIDTH < AUDIO_BIT_WIDTH + 1) begin : g_bad_slot
        $error("i2s_transmitter: SLOT_WIDTH must be at least AUDIO_BIT_WIDTH+1");
    end
    if (BCLK_DIV < 1) begin : g_bad_div
        $error("i2s_transmitter: BCLK_DIV must be at least 1");
    end
    if (AUDIO_BIT_WIDTH < 2) begin : g_bad_width
        $error("i2s_transmitter: AUDIO_BIT_WIDTH must be at least 2");
    end

    logic [DIV_W-1:0]           div_cnt;
    logic [BIT_W-1:0]           bit_cnt;
    logic [AUDIO_BIT_WIDTH-1:0] word;

    logic [BIT_W-1:0] bit_next;
    logic [BIT_W-1:0] slot_pos;
    logic             lrclk_next;
    logic             sdata_next;

    // Values for the position entered on the next BCLK falling edge; p=0 and
    // p>AUDIO_BIT_WIDTH send padding zeros, giving the one-BCLK I2S delay.
    always_comb begin
        bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        lrclk_next = (bit_next >= SLOT_POS);
        slot_pos   = lrclk_next ? bit_next - SLOT_POS : bit_next;
        sdata_next = 1'b0;
        for (int unsigned i = 0; i < AUDIO_BIT_WIDTH; i++) begin
            if (slot_pos == BIT_W'(AUDIO_BIT_WIDTH - i)) begin
                sdata_next = word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            sample_req <= 1'b0;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sdata  <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                i2s_bclk <= ~i2s_bclk;
                if (i2s_bclk) begin
                    bit_cnt   <= bit_next;
                    i2s_lrclk <= lrclk_next;
                    i2s_sdata <= sdata_next;
                    if (bit_next == '0) begin
                        word       <= {~audio_in[AUDIO_BIT_WIDTH-1], audio_in[AUDIO_BIT_WIDTH-2:0]};
                        sample_req <= 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: stimulus queues expected frame words,
// a monitor decodes the bus on BCLK rising edges and checks timing and data.
module tb_i2s_transmitter;

    localparam int AW  = 8;
    localparam int SW  = 16;
    localparam int DIV = 2;
    localparam int FRAME_CLKS = 4 * SW * DIV;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] audio_in;
    logic          sample_req;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] exp_q[$];

    i2s_transmitter #(
        .AUDIO_BIT_WIDTH(AW),
        .SLOT_WIDTH     (SW),
        .BCLK_DIV       (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .audio_in  (audio_in),
        .sample_req(sample_req),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic wait_req();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME_CLKS + 20 && !seen; i++) begin
            @(negedge clk);
            if (sample_req) seen = 1'b1;
        end
        chk("sample_req_timeout", int'(seen), 1);
    endtask

    // Stimulus: expected word for each frame is pushed before its latch point.
    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        audio_in = 8'hFF;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h7F);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_req();

        // Input change mid-frame must not disturb the frame in flight.
        repeat (40) @(posedge clk);
        #1 audio_in = 8'h00;
        exp_q.push_back(8'h80);
        wait_req();

        audio_in = 8'h80; exp_q.push_back(8'h00); wait_req();
        audio_in = 8'h7F; exp_q.push_back(8'hFF); wait_req();
        audio_in = 8'h01; exp_q.push_back(8'h81); wait_req();
        audio_in = 8'hC3; exp_q.push_back(8'h43); wait_req();

        // One-cycle reset mid right slot; partial frame abandoned.
        repeat (80) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        audio_in = 8'h3C;
        exp_q.push_back(8'hBC);

        // Drop enable so that enabled clock 200 is the clearing edge.
        repeat (199) @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 exp_q.delete();
        exp_q.push_back(8'h00);
        audio_in = 8'h55;
        exp_q.push_back(8'hD5);
        enable = 1'b1;
        wait_req();

        repeat (FRAME_CLKS + 4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: decodes slots on BCLK rising edges and pops one word per frame.
    initial begin
        bit        act, rise_ev, fall_ev;
        bit        lr_bad, pad_bad, chg_bad;
        int        en_cnt, rises, falls, last_req, pos, p;
        logic      pb, plr, psd;
        logic [AW-1:0] cur, lw, exp_w;
        en_cnt = 0; rises = 0; falls = 0; last_req = 0;
        pb = 1'b0; plr = 1'b0; psd = 1'b0;
        lr_bad = 1'b0; pad_bad = 1'b0; chg_bad = 1'b0;
        cur = '0; lw = '0;
        forever begin
            @(posedge clk);
            act = rst_n && enable;
            @(negedge clk);
            if (!act) begin
                chk("idle_outputs", int'({sample_req, i2s_bclk, i2s_lrclk, i2s_sdata}), 0);
                en_cnt = 0; rises = 0; falls = 0; last_req = 0;
                pb = 1'b0; plr = 1'b0; psd = 1'b0;
                lr_bad = 1'b0; pad_bad = 1'b0; chg_bad = 1'b0;
            end else begin
                en_cnt++;
                rise_ev = !pb && i2s_bclk;
                fall_ev = pb && !i2s_bclk;
                if (!fall_ev && (i2s_lrclk != plr || i2s_sdata != psd)) chg_bad = 1'b1;
                if (fall_ev) begin
                    if (falls == 0) chk("first_bclk_fall_clock", en_cnt, 2 * DIV);
                    falls++;
                end
                if (rise_ev) begin
                    if (rises == 0) chk("first_bclk_rise_clock", en_cnt, DIV);
                    pos = rises % (2 * SW);
                    p   = pos % SW;
                    if (pos == 0) begin
                        lr_bad = 1'b0; pad_bad = 1'b0; chg_bad = 1'b0;
                    end
                    if (i2s_lrclk != (pos >= SW)) lr_bad = 1'b1;
                    if (p >= 1 && p <= AW) cur[AW-p] = i2s_sdata;
                    else if (i2s_sdata) pad_bad = 1'b1;
                    if (pos == SW - 1) lw = cur;
                    if (pos == 2 * SW - 1) begin
                        chk("expected_word_available", int'(exp_q.size() != 0), 1);
                        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                        chk("left_slot_word", int'(lw), int'(exp_w));
                        chk("right_slot_word", int'(cur), int'(exp_w));
                        chk("lrclk_slot_pattern", int'(lr_bad), 0);
                        chk("zero_padding", int'(pad_bad), 0);
                        chk("change_only_on_bclk_fall", int'(chg_bad), 0);
                    end
                    rises++;
                end
                if (sample_req) begin
                    chk("sample_req_spacing", en_cnt, last_req + FRAME_CLKS);
                    last_req = en_cnt;
                end
                pb = i2s_bclk; plr = i2s_lrclk; psd = i2s_sdata;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
Output stage directly downstream of the mixer. Takes the mixer's unsigned offset-binary mono sample and converts it to two's complement. Serializes the sample onto a standard Philips I2S bus (BCLK/LRCLK/SDATA) to the board DAC, with the same sample on both channels. Generates its own bit and word clocks from the system clock, latches one mixer sample per frame and pulses `sample_req` at that instant.

Parameters:
- AUDIO_BIT_WIDTH, default CONFIG::AUDIO_BIT_WIDTH: width of `audio_in` and of the data word sent per slot.
- SLOT_WIDTH, default 32: BCLK periods per channel slot. Must satisfy SLOT_WIDTH >= AUDIO_BIT_WIDTH+1; elaboration-time assertion otherwise.
- BCLK_DIV, default 4: system clocks per BCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  run when high; bus idles when low.
- audio_in  input  AUDIO_BIT_WIDTH  unsigned offset-binary sample from the mixer, combinational source.
- sample_req  output  1  one-clock pulse in the cycle `audio_in` is latched.
- i2s_bclk  output  1  bit clock, registered.
- i2s_lrclk  output  1  word select, registered; 0 = left, 1 = right.
- i2s_sdata  output  1  serial data, registered, MSB first.

Behaviour:
Reset and enable:
- rst_n low at a clock edge: `i2s_bclk`, `i2s_lrclk`, `i2s_sdata` and `sample_req` go to 0.
- Same edge: `div_cnt`=0, `bit_cnt`=0, latched word=0. Reset wins over everything else.
- enable low (rst_n high): identical clearing next edge. On re-enable, operation restarts exactly as after reset.

Clock generation:
- `div_cnt` counts 0..BCLK_DIV-1 on enabled cycles.
- When `div_cnt`==BCLK_DIV-1: `i2s_bclk` toggles and `div_cnt` wraps to 0.
- The BCLK rising edge is the clock where `i2s_bclk` goes 0->1; the falling edge is the clock where it goes 1->0.
- Falling edges occur every 2*BCLK_DIV enabled clocks; the first is the 2*BCLK_DIV-th enabled clock after reset release.

Bit position:
- `bit_cnt` (0..2*SLOT_WIDTH-1) advances by 1 on each falling edge and wraps from 2*SLOT_WIDTH-1 to 0.
- All of `i2s_lrclk`, `i2s_sdata` and `bit_cnt` update only on falling edges. The DAC samples on BCLK rising edges.

Per falling edge, with new position k and p = k mod SLOT_WIDTH:
- `i2s_lrclk` = (k >= SLOT_WIDTH).
- `i2s_sdata` = word[AUDIO_BIT_WIDTH-p] when 1 <= p <= AUDIO_BIT_WIDTH, else 0.
- This gives the I2S one-BCLK delay after each LRCLK transition, with zero padding after the LSB.

Frame latch:
- On the falling edge where k wraps to 0, word <= audio_in with the MSB inverted (audio_in ^ (1 << (AUDIO_BIT_WIDTH-1))).
- `sample_req`=1 in that same cycle only.
- Position 0 outputs 0, so the new word is first visible at p=1.
- Frame period = 4*SLOT_WIDTH*BCLK_DIV enabled clocks.

Simultaneous and boundary cases:
- Changes of `audio_in` between latch points are ignored.
- The first frame after reset sends word 0, i.e. all-zero data.
- Both slots of a frame carry the identical word.
- With BCLK_DIV=1, `i2s_bclk` toggles every clock.

Implementation:
- Counters and shift/index logic only; no FIFO.
- The word register is the only sample storage.

Test Plan (AUDIO_BIT_WIDTH=8, SLOT_WIDTH=16, BCLK_DIV=2; frame = 128 clocks):
- Reset release, enable=1, audio_in=8'hFF -> `i2s_bclk` rises at clock 2 and falls at clock 4. Frame 0 SDATA is all zero. `sample_req` pulses once at clock 128. Frame 1 left slot bits p1..p8 = 0,1,1,1,1,1,1,1 (8'h7F); right slot identical.
- audio_in=8'h80 latched -> data bits all 0 (signed 0); audio_in=8'h00 latched -> 1,0,0,0,0,0,0,0 (8'h80).
- `i2s_lrclk` check -> low for positions 0..15, high for 16..31, toggling every 64 clocks and only on BCLK falling edges. `sample_req` pulse spacing is exactly 128 clocks.
- audio_in changed from 8'hFF to 8'h00 mid-frame -> current frame keeps 8'h7F in both slots; next frame carries 8'h80.
- enable dropped at clock 200 -> all outputs 0 by the next edge. Re-enable -> first falling edge 4 clocks later, first `sample_req` 128 clocks later.
- rst_n low for one cycle mid-right-slot with enable=1 -> outputs 0 the next cycle, counters restart as in the first scenario, and the partial frame is not resumed.
